// File: rtl/pool_layer_sched.sv
// rtl/pool_layer_sched.sv - layer sequencer feeding the pooling engine one channel at a time
// Walks C channels of an FxF map, issues feature reads, aligns engine valids, counts result writes.
module pool_layer_sched #(
  parameter int LWIDTH = 10,
  parameter int AWIDTH = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              req,
  input  logic [LWIDTH-1:0] fea_size,
  input  logic [LWIDTH-1:0] pool_size,
  input  logic [LWIDTH-1:0] n_chan,
  input  logic [AWIDTH-1:0] in_base,
  input  logic [AWIDTH-1:0] out_base,
  input  logic              eng_valid,
  input  logic              eng_stop,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [LWIDTH-1:0] cfg_fea_size,
  output logic [LWIDTH-1:0] cfg_pool,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_raddr,
  output logic              eng_start,
  output logic              eng_in_valid,
  output logic              eng_in_stop,
  output logic              out_we,
  output logic [AWIDTH-1:0] out_waddr
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_DRAIN, S_DONE} state_t;

  localparam logic [2*LWIDTH-1:0] ONE_W = 1;
  localparam logic [LWIDTH-1:0]   ONE_L = 1;
  localparam logic [AWIDTH-1:0]   ONE_A = 1;

  state_t              state_q, state_d;
  logic [LWIDTH-1:0]   fea_q, fea_d, pool_q, pool_d, nch_q, nch_d, ch_q, ch_d;
  logic [2*LWIDTH-1:0] ff_q, ff_d, pix_q, pix_d;
  logic [AWIDTH-1:0]   base_q, base_d, waddr_q, waddr_d;
  logic [RD_LAT-1:0]   vpipe_q, vpipe_d, spipe_q, spipe_d;
  logic                busy_q, busy_d, ack_q, ack_d, err_q, err_d;
  logic                bad_q, bad_d, hold_q, hold_d;
  logic                cfg_bad, last_pix, last_ch, stop_ok;

  assign cfg_bad  = (pool_size == '0) || (pool_size > fea_size) || (n_chan == '0);
  assign last_pix = (pix_q == ff_q - ONE_W);
  assign last_ch  = (ch_q == nch_q - ONE_L);
  // A stop seen early is held; the channel only closes once every delayed valid has left.
  assign stop_ok  = (eng_stop || hold_q) && (vpipe_q == '0);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = cfg_bad ? S_DONE : S_START;
      S_START: state_d = S_FEED;
      S_FEED:  if (last_pix) state_d = S_DRAIN;
      S_DRAIN: if (stop_ok) state_d = last_ch ? S_DONE : S_START;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_re    = (state_q == S_FEED);
    mem_raddr = mem_re ? base_q + AWIDTH'(pix_q) : '0;
    eng_start = (state_q == S_START);
    out_we    = eng_valid && ((state_q == S_FEED) || (state_q == S_DRAIN));
  end

  assign busy         = busy_q;
  assign ack          = ack_q;
  assign err          = err_q;
  assign cfg_fea_size = fea_q;
  assign cfg_pool     = pool_q;
  assign eng_in_valid = vpipe_q[RD_LAT-1];
  assign eng_in_stop  = spipe_q[RD_LAT-1];
  assign out_waddr    = waddr_q;

  always_comb begin
    fea_d   = fea_q;
    pool_d  = pool_q;
    nch_d   = nch_q;
    ch_d    = ch_q;
    ff_d    = ff_q;
    pix_d   = pix_q;
    base_d  = base_q;
    waddr_d = waddr_q;
    busy_d  = busy_q;
    bad_d   = bad_q;
    hold_d  = hold_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    vpipe_d[0] = mem_re;
    spipe_d[0] = mem_re && last_pix;
    for (int i = 1; i < RD_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      spipe_d[i] = spipe_q[i-1];
    end
    if (out_we) waddr_d = waddr_q + ONE_A;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          fea_d   = fea_size;
          pool_d  = pool_size;
          nch_d   = n_chan;
          ch_d    = '0;
          ff_d    = (2*LWIDTH)'(fea_size) * (2*LWIDTH)'(fea_size);
          base_d  = in_base;
          waddr_d = out_base;
          busy_d  = 1'b1;
          bad_d   = cfg_bad;
        end
      end
      S_START: begin
        pix_d  = '0;
        hold_d = 1'b0;
      end
      S_FEED: begin
        pix_d = pix_q + ONE_W;
        if (eng_stop) hold_d = 1'b1;
      end
      S_DRAIN: begin
        if (eng_stop) hold_d = 1'b1;
        if (stop_ok && !last_ch) begin
          ch_d   = ch_q + ONE_L;
          base_d = base_q + AWIDTH'(ff_q);
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
        ack_d  = 1'b1;
        err_d  = bad_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      fea_q   <= '0;
      pool_q  <= '0;
      nch_q   <= '0;
      ch_q    <= '0;
      ff_q    <= '0;
      pix_q   <= '0;
      base_q  <= '0;
      waddr_q <= '0;
      vpipe_q <= '0;
      spipe_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      fea_q   <= fea_d;
      pool_q  <= pool_d;
      nch_q   <= nch_d;
      ch_q    <= ch_d;
      ff_q    <= ff_d;
      pix_q   <= pix_d;
      base_q  <= base_d;
      waddr_q <= waddr_d;
      vpipe_q <= vpipe_d;
      spipe_q <= spipe_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
      hold_q  <= hold_d;
    end
  end
endmodule
